// File: rtl/arith_serial_m.sv
// Lane-serial add/subtract: one LANE_WIDTH slice per clock, carry held in a register between slices.
// Optional zero/neg result flags are built when ARITH_ZN_FLAGS_EN is defined.
module arith_serial_m #(
   parameter  int WORD_SIZE  = 16,
   parameter  int LANE_WIDTH = 4,
   localparam int LANES      = WORD_SIZE / LANE_WIDTH,
   localparam int LANE_SEL_W = $clog2(LANES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LANE_SEL_W-1:0] op_lanes,
   input  logic                  sub_op,
   input  logic                  carry_op,
   input  logic                  carry_in,
   input  logic [WORD_SIZE-1:0]  src_a,
   input  logic [WORD_SIZE-1:0]  src_b,
   output logic                  ready,
   output logic                  done,
   output logic [WORD_SIZE-1:0]  result,
   output logic                  carry,
`ifdef ARITH_ZN_FLAGS_EN
   output logic                  zero,
   output logic                  neg,
`endif
   output logic                  ovf
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [WORD_SIZE-1:0]    a_q, a_d;
   logic [WORD_SIZE-1:0]    b_q, b_d;
   logic [LANE_SEL_W-1:0]   lanes_q, lanes_d;
   logic [LANE_SEL_W-1:0]   idx_q, idx_d;
   logic                    c_q, c_d;
   logic [WORD_SIZE-1:0]    result_q, result_d;
   logic                    carry_q, carry_d;
   logic                    ovf_q, ovf_d;
`ifdef ARITH_ZN_FLAGS_EN
   logic                    zero_q, zero_d;
   logic                    neg_q, neg_d;
`endif

   logic [LANE_WIDTH-1:0]   a_lane, b_lane;
   logic [LANE_WIDTH:0]     sum_w;
   logic                    msb_cin;
   logic                    last_lane;
   logic                    accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         lanes_q  <= '0;
         idx_q    <= '0;
         c_q      <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ARITH_ZN_FLAGS_EN
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         lanes_q  <= lanes_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
`ifdef ARITH_ZN_FLAGS_EN
         zero_q   <= zero_d;
         neg_q    <= neg_d;
`endif
      end
   end

   // Lane select and slice adder; carry into the MSB is recovered from sum ^ a ^ b.
   always_comb begin
      a_lane = '0;
      b_lane = '0;
      for (int l = 0; l < LANES; l++) begin
         if (idx_q == LANE_SEL_W'(l)) begin
            a_lane = a_q[l*LANE_WIDTH +: LANE_WIDTH];
            b_lane = b_q[l*LANE_WIDTH +: LANE_WIDTH];
         end
      end
      sum_w     = {1'b0, a_lane} + {1'b0, b_lane} + {{LANE_WIDTH{1'b0}}, c_q};
      msb_cin   = sum_w[LANE_WIDTH-1] ^ a_lane[LANE_WIDTH-1] ^ b_lane[LANE_WIDTH-1];
      // op_lanes 0 wraps to LANES-1 here, which is exactly the "0 means LANES" encoding.
      last_lane = (idx_q == (lanes_q - LANE_SEL_W'(1)));
      accept    = start && (state_q != RUN);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_lane) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q != RUN);
      done  = (state_q == DONE);
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      lanes_d  = lanes_q;
      idx_d    = idx_q;
      c_d      = c_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
`ifdef ARITH_ZN_FLAGS_EN
      zero_d   = zero_q;
      neg_d    = neg_q;
`endif
      if (accept) begin
         a_d      = src_a;
         b_d      = src_b ^ {WORD_SIZE{sub_op}};
         lanes_d  = op_lanes;
         idx_d    = '0;
         c_d      = (carry_in & carry_op) ^ sub_op;
         result_d = '0;
      end else if (state_q == RUN) begin
         for (int l = 0; l < LANES; l++) begin
            if (idx_q == LANE_SEL_W'(l)) result_d[l*LANE_WIDTH +: LANE_WIDTH] = sum_w[LANE_WIDTH-1:0];
         end
         c_d = sum_w[LANE_WIDTH];
         if (last_lane) begin
            carry_d = sum_w[LANE_WIDTH];
            ovf_d   = msb_cin ^ sum_w[LANE_WIDTH];
`ifdef ARITH_ZN_FLAGS_EN
            // Inactive lanes were cleared on accept, so a whole-word test covers only active lanes.
            zero_d  = (result_d == '0);
            neg_d   = sum_w[LANE_WIDTH-1];
`endif
         end else begin
            idx_d = idx_q + LANE_SEL_W'(1);
         end
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign ovf    = ovf_q;
`ifdef ARITH_ZN_FLAGS_EN
   assign zero   = zero_q;
   assign neg    = neg_q;
`endif

endmodule

// File: tb/tb_arith_serial_m.sv
// Bench for arith_serial_m: directed and random operations against a whole-word arithmetic model.
module tb_arith_serial_m;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op_lanes;
   logic        sub_op, carry_op, carry_in;
   logic [15:0] src_a, src_b;
   logic        ready, done, carry, ovf;
   logic [15:0] result;
`ifdef ARITH_ZN_FLAGS_EN
   logic        zero, neg;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arith_serial_m #(.WORD_SIZE(16), .LANE_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_lanes(op_lanes),
      .sub_op(sub_op), .carry_op(carry_op), .carry_in(carry_in),
      .src_a(src_a), .src_b(src_b), .ready(ready), .done(done),
      .result(result), .carry(carry),
`ifdef ARITH_ZN_FLAGS_EN
      .zero(zero), .neg(neg),
`endif
      .ovf(ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Whole-word view: n lanes form one n*4-bit add of a and (optionally inverted) b.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input int n,
                        input bit sub, input bit cop, input bit cin,
                        output logic [15:0] r, output bit c, output bit o,
                        output bit z, output bit ng);
      int w;
      longint unsigned m, av, bv, full, sa, sb;
      w    = n * 4;
      m    = (64'd1 << w) - 1;
      av   = a & m;
      bv   = (sub ? ~{48'd0, b} : {48'd0, b}) & m;
      full = av + bv + ((cin & cop) ^ sub);
      r    = 16'(full & m);
      c    = bit'((full >> w) & 1);
      sa   = (av >> (w - 1)) & 1;
      sb   = (bv >> (w - 1)) & 1;
      ng   = bit'((full >> (w - 1)) & 1);
      o    = (sa == sb) && (ng != bit'(sa));
      z    = (r == 16'd0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] lanes, input bit sub, input bit cop,
                         input bit cin, input bit pulse);
      int n, cnt, rdy_low;
      bit seen, ec, eo, ez, en;
      logic [15:0] er;
      n = (lanes == 2'd0) ? 4 : int'(lanes);
      model(a, b, n, sub, cop, cin, er, ec, eo, ez, en);
      @(negedge clk);
      src_a = a; src_b = b; op_lanes = lanes;
      sub_op = sub; carry_op = cop; carry_in = cin; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      src_a = 16'($urandom); src_b = 16'($urandom);
      cnt = 0; rdy_low = 0; seen = 1'b0;
      while (!seen && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (done) seen = 1'b1;
         else begin
            if (!ready) rdy_low++;
            start = (pulse && cnt < n) ? 1'($urandom % 2) : 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, seen ? cnt : 0, n + 1);
      check({tag, "_ready_low"}, rdy_low, n);
      check({tag, "_result"}, result, er);
      check({tag, "_carry"}, carry, ec);
      check({tag, "_ovf"}, ovf, eo);
`ifdef ARITH_ZN_FLAGS_EN
      check({tag, "_zero"}, zero, ez);
      check({tag, "_neg"}, neg, en);
`endif
      @(negedge clk);
      check({tag, "_done_once"}, done, 0);
      check({tag, "_idle_ready"}, ready, 1);
      check({tag, "_held"}, result, er);
   endtask

   initial begin
      int dcnt;
      rst = 1'b1; start = 1'b0; op_lanes = '0; sub_op = 1'b0;
      carry_op = 1'b0; carry_in = 1'b0; src_a = '0; src_b = '0;
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      check("rst_ovf", ovf, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("add4", 16'h7FFF, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("sub4", 16'h0005, 16'h0007, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("addc2", 16'h12FF, 16'h3400, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      run_op("sub1", 16'h0008, 16'h0001, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("pulse4", 16'hABCD, 16'h1357, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // start held high: a new op every 5 cycles, done at cycles 5, 10, 15
      @(negedge clk);
      src_a = 16'hFFFF; src_b = 16'h0001; op_lanes = 2'd0;
      sub_op = 1'b0; carry_op = 1'b0; carry_in = 1'b0; start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         check("hold_done_timing", done, (c % 5 == 0) ? 1 : 0);
         if (done) begin
            check("hold_result", result, 16'h0000);
            check("hold_carry", carry, 1);
            check("hold_ovf", ovf, 0);
         end
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("hold_drained", ready, 1);

      // reset while lane 2 is about to be computed
      src_a = 16'h1111; src_b = 16'h2222; op_lanes = 2'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_partial", result, 16'h0033);
      #2 rst = 1'b1;
      #1;
      check("midrst_result", result, 0);
      check("midrst_carry", carry, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_ready", ready, 1);
      check("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("midrst_no_done", dcnt, 0);
      run_op("after_rst", 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("after_rst_value", result, 16'h2345);

      for (int k = 0; k < 40; k++) begin
         run_op("rand", 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
